// File: rtl/seq_detector_driver.sv
// seq_detector_driver: sequences a serial-bit sequence detector.
// Resets the detector, streams a latched pattern MSB-first (pattern[len-1]
// first), samples the detector's Moore output after every shifted bit and
// reports the hit count and the index of the first hit.
// Optional feature macro: PATTERN_REPEAT_EN adds input repeat_n[3:0] and
// streams the pattern repeat_n+1 times back-to-back.
module seq_detector_driver #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] length,
`ifdef PATTERN_REPEAT_EN
  input  logic [3:0]       repeat_n,
`endif
  input  logic             det_out,
  output logic             det_w,
  output logic             det_resetn,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] match_count,
  output logic [LEN_W-1:0] first_match_idx,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] PAT_LEN  = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] IDX_NONE = {LEN_W{1'b1}};
  // Real indices stop one short of all-ones so "no hit" stays unambiguous.
  localparam logic [LEN_W-1:0] IDX_MAX  = {{(LEN_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_k;        // bit position within the current pass
  logic [LEN_W-1:0] r_cidx;     // global index of the bit now on det_w
  logic [LEN_W-1:0] r_sidx;     // global index of the previously shifted bit
  logic             r_sval;     // a bit has already been shifted this run
  logic [3:0]       r_rpt;      // passes still to stream after this one
  logic             r_det_w;
  logic             r_det_resetn;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;
  logic [CNT_W-1:0] r_match_cnt;
  logic [LEN_W-1:0] r_first_idx;

  logic [LEN_W-1:0] w_eff_len;
  logic             w_last;
  logic [PAT_W-1:0] w_pat_first;
  logic [PAT_W-1:0] w_pat_next;
  logic             w_first_bit;
  logic             w_next_bit;
  logic             w_hit;
  logic [3:0]       w_rpt_in;

`ifdef PATTERN_REPEAT_EN
  assign w_rpt_in = repeat_n;
`else
  assign w_rpt_in = 4'd0;
`endif

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc_idx(input logic [LEN_W-1:0] v);
    return (v >= IDX_MAX) ? IDX_MAX : v + LEN_W'(1);
  endfunction

  // Length clipping, bit selection for the stream and hit qualification
  always_comb begin
    w_eff_len   = (length > PAT_LEN) ? PAT_LEN : length;
    w_last      = (r_k == (r_len - LEN_W'(1)));
    w_pat_first = r_pat >> (r_len - LEN_W'(1));
    w_pat_next  = r_pat >> (r_len - r_k - LEN_W'(2));
    w_first_bit = w_pat_first[0];
    w_next_bit  = w_pat_next[0];
    // det_out reflects the previously shifted bit in later SHIFT cycles and DRAIN
    w_hit = det_out && !abort &&
            (((r_state == S_SHIFT) && r_sval) || (r_state == S_DRAIN));
  end

  // Controller FSM: sequencing, bit streaming, hit sampling and result registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_pat        <= '0;
      r_len        <= '0;
      r_k          <= '0;
      r_cidx       <= '0;
      r_sidx       <= '0;
      r_sval       <= 1'b0;
      r_rpt        <= 4'd0;
      r_det_w      <= 1'b0;
      r_det_resetn <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_match_cnt  <= '0;
      r_first_idx  <= IDX_NONE;
    end else if (abort && r_busy) begin
      // Cancel: keep partial results, hold detector in reset
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b1;
      r_det_w      <= 1'b0;
      r_det_resetn <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_det_w      <= 1'b0;
          r_det_resetn <= 1'b0;
          if (start && (w_eff_len != '0)) begin
            r_pat       <= pattern;
            r_len       <= w_eff_len;
            r_k         <= '0;
            r_cidx      <= '0;
            r_sidx      <= '0;
            r_sval      <= 1'b0;
            r_rpt       <= w_rpt_in;
            r_match_cnt <= '0;
            r_first_idx <= IDX_NONE;
            r_busy      <= 1'b1;
            r_state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_state      <= S_SHIFT;
          r_det_resetn <= 1'b1;
          r_det_w      <= w_first_bit;
        end
        S_SHIFT: begin
          r_sidx <= r_cidx;
          r_sval <= 1'b1;
          r_cidx <= sat_inc_idx(r_cidx);
          if (w_last) begin
            if (r_rpt != 4'd0) begin
              // Next pass follows immediately, detector keeps its history
              r_rpt   <= r_rpt - 4'd1;
              r_k     <= '0;
              r_det_w <= w_first_bit;
            end else begin
              r_state <= S_DRAIN;
              r_det_w <= 1'b0;
            end
          end else begin
            r_k     <= r_k + LEN_W'(1);
            r_det_w <= w_next_bit;
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_det_w <= 1'b0;
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_det_resetn <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_det_w      <= 1'b0;
          r_det_resetn <= 1'b0;
        end
      endcase
      if (w_hit) begin
        r_match_cnt <= sat_inc_cnt(r_match_cnt);
        if (r_first_idx == IDX_NONE) begin
          r_first_idx <= r_sidx;
        end
      end
    end
  end

  assign det_w           = r_det_w;
  assign det_resetn      = r_det_resetn;
  assign busy            = r_busy;
  assign done            = r_done;
  assign aborted         = r_aborted;
  assign match_count     = r_match_cnt;
  assign first_match_idx = r_first_idx;
  assign state           = r_state;

endmodule

// File: tb/tb_seq_detector_driver.sv
// Bench for seq_detector_driver: models a 1111/1101 Moore detector and
// predicts hit results from the streamed bit sequence.
module tb_seq_detector_driver;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] pattern = 16'd0;
  logic [4:0]  length = 5'd0;
  logic        det_out;
  logic        det_w;
  logic        det_resetn;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [3:0]  match_count;
  logic [4:0]  first_match_idx;
  logic [2:0]  state;
  logic [3:0]  hist = 4'd0;

  int checks = 0;
  int errors = 0;

  seq_detector_driver #(.PAT_W(16), .LEN_W(5), .CNT_W(4)) dut (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort),
    .pattern(pattern), .length(length),
`ifdef PATTERN_REPEAT_EN
    .repeat_n(4'd0),
`endif
    .det_out(det_out), .det_w(det_w), .det_resetn(det_resetn),
    .busy(busy), .done(done), .aborted(aborted),
    .match_count(match_count), .first_match_idx(first_match_idx),
    .state(state)
  );

  always #5 clock = ~clock;

  // Detector model: synchronous active-low reset, Moore output on last 4 bits
  always @(posedge clock) begin
    if (!det_resetn) hist <= 4'd0;
    else             hist <= {hist[2:0], det_w};
  end
  assign det_out = (hist == 4'b1111) || (hist == 4'b1101);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected results: slide a 4-bit window over the sent bit sequence
  task automatic ref_model(input logic [15:0] p, input int l, output int cnt, output int first);
    logic [3:0] w;
    w = 4'd0;
    cnt = 0;
    first = 31;
    for (int i = 0; i < l; i++) begin
      w = {w[2:0], p[l-1-i]};
      if (i >= 3 && (w == 4'b1111 || w == 4'b1101)) begin
        if (cnt < 15) cnt++;
        if (first == 31) first = i;
      end
    end
  endtask

  task automatic run_check(input logic [15:0] p, input logic [4:0] l, input bit poke);
    int le, ecnt, efirst;
    le = (l > 5'd16) ? 16 : int'(l);
    ref_model(p, le, ecnt, efirst);
    @(negedge clock);
    pattern = p; length = l; start = 1'b1; abort = poke;
    @(posedge clock);
    #1 start = 1'b0; abort = 1'b0;
    if (le == 0) begin
      @(negedge clock);
      chk("len0_state", state, 0);
      chk("len0_busy", busy, 0);
      return;
    end
    for (int n = 1; n <= le + 3; n++) begin
      @(negedge clock);
      if (n == 1) begin
        chk("clear_state", state, 1);
        chk("clear_det_resetn", det_resetn, 0);
      end else if (n <= le + 1) begin
        chk("shift_state", state, 2);
        chk("det_w", det_w, p[le-n+1]);
      end else if (n == le + 2) begin
        chk("drain_state", state, 3);
      end else begin
        chk("done_state", state, 4);
      end
      chk("busy", busy, n <= le + 2);
      chk("done", done, n == le + 3);
      if (poke && n == 2) start = 1'b1;
      if (poke && n == 3) start = 1'b0;
      if (poke && n == le + 3) abort = 1'b1;
    end
    chk("match_count", match_count, ecnt);
    chk("first_match_idx", first_match_idx, efirst);
    @(negedge clock);
    abort = 1'b0;
    chk("idle_state", state, 0);
    chk("no_aborted", aborted, 0);
    chk("hold_count", match_count, ecnt);
    chk("hold_first", first_match_idx, efirst);
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_state", state, 0);
    chk("rst_det_w", det_w, 0);
    chk("rst_det_resetn", det_resetn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_count", match_count, 0);
    chk("rst_first", first_match_idx, 31);
    resetn = 1'b1;

    // Directed patterns, including start+abort together and clipping
    run_check(16'h000D, 5'd4, 1'b0);
    run_check(16'h003F, 5'd6, 1'b0);
    run_check(16'h006D, 5'd7, 1'b1);
    run_check(16'h0000, 5'd4, 1'b0);
    run_check(16'h000D, 5'd0, 1'b0);
    run_check(16'hFFFF, 5'd20, 1'b0);
    run_check(16'hB6DB, 5'd16, 1'b1);

    // Abort in SHIFT k=2
    @(negedge clock);
    pattern = 16'h000D; length = 5'd4; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (4) @(negedge clock);
    chk("abort_pre_state", state, 2);
    abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    @(negedge clock);
    chk("abort_state", state, 0);
    chk("abort_pulse", aborted, 1);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_det_resetn", det_resetn, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("abort_pulse_end", aborted, 0);
      chk("abort_no_done", done, 0);
      chk("abort_stay_idle", state, 0);
    end

    // Reset in the middle of SHIFT
    @(negedge clock);
    pattern = 16'h003F; length = 5'd6; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (7) @(negedge clock);
    chk("mid_state", state, 2);
    chk("mid_count", match_count, 1);
    chk("mid_first", first_match_idx, 3);
    resetn = 1'b0;
    #1;
    chk("mrst_state", state, 0);
    chk("mrst_det_resetn", det_resetn, 0);
    chk("mrst_count", match_count, 0);
    chk("mrst_first", first_match_idx, 31);
    chk("mrst_busy", busy, 0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("mrst_idle", state, 0);
    chk("mrst_no_done", done, 0);
    chk("mrst_no_aborted", aborted, 0);

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      logic [15:0] rp;
      logic [4:0]  rl;
      bit          rk;
      rp = 16'($urandom);
      rl = 5'($urandom_range(0, 20));
      rk = 1'($urandom % 2);
      run_check(rp, rl, rk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
